// File: rtl/issue_ctrl.sv
// Dual-issue scheduler: decides per fetch pair whether to dual-issue, split the
// pair over two cycles, stall on load-use / multi-cycle hazards, or flush on a
// redirect. Drives IF/ID stall/flush/two_issue controls and the fetch PC step.
module issue_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       s0_valid,
  input  logic       s1_valid,
  input  logic [4:0] s0_rs1,
  input  logic [4:0] s0_rs2,
  input  logic [4:0] s0_rd,
  input  logic [4:0] s1_rs1,
  input  logic [4:0] s1_rs2,
  input  logic [4:0] s1_rd,
  input  logic       s0_reg_write,
  input  logic       s1_reg_write,
  input  logic       s0_mem,
  input  logic       s1_mem,
  input  logic       s0_branch,
  input  logic       s1_branch,
  input  logic       s0_multi,
  input  logic       s1_multi,
  input  logic       ex_load0,
  input  logic       ex_load1,
  input  logic [4:0] ex_rd0,
  input  logic [4:0] ex_rd1,
  input  logic       mc_done,
  input  logic       redirect,
  output logic       ID_stall,
  output logic       IF_flush,
  output logic       two_issue,
  output logic       issue_sel,
  output logic [3:0] pc_step,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    StRun   = 3'd0,
    StSplit = 3'd1,
    StLu    = 3'd2,
    StMcw   = 3'd3,
    StFlush = 3'd4
  } state_e;

  state_e state_q, state_d;

  logic raw_pair;
  logic pair_ok;
  logic s0_lu;
  logic s1_lu;
  logic lu_run;
  logic unused_inputs;

  // A source register hits a load still sitting in ID/EX (x0 never hazards).
  function automatic logic lu_hit(input logic [4:0] rs, input logic ld0, input logic [4:0] rd0,
                                  input logic ld1, input logic [4:0] rd1);
    return (rs != 5'd0) && ((ld0 && (rs == rd0)) || (ld1 && (rs == rd1)));
  endfunction

  assign raw_pair = s0_reg_write && (s0_rd != 5'd0) && ((s0_rd == s1_rs1) || (s0_rd == s1_rs2));
  assign pair_ok  = s0_valid && s1_valid && !raw_pair && !(s0_mem && s1_mem) && !s0_branch &&
                    !s0_multi && !s1_multi;

  assign s0_lu = lu_hit(s0_rs1, ex_load0, ex_rd0, ex_load1, ex_rd1) ||
                 lu_hit(s0_rs2, ex_load0, ex_rd0, ex_load1, ex_rd1);
  assign s1_lu = lu_hit(s1_rs1, ex_load0, ex_rd0, ex_load1, ex_rd1) ||
                 lu_hit(s1_rs2, ex_load0, ex_rd0, ex_load1, ex_rd1);

  // Slot1 only counts toward load-use when it would issue alongside slot0.
  assign lu_run = (s0_valid && s0_lu) || (pair_ok && s1_lu);

  // Slot1's writeback and branch kind never constrain pairing (it is last in the pair).
  assign unused_inputs = ^{s1_rd, s1_reg_write, s1_branch};

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and Mealy output decode; outputs forced idle while reset is asserted.
  always_comb begin
    state_d   = state_q;
    ID_stall  = 1'b0;
    IF_flush  = 1'b0;
    two_issue = 1'b0;
    issue_sel = 1'b0;
    pc_step   = 4'd0;
    unique case (state_q)
      // LU re-evaluates the held pair exactly as RUN does; the stall cycle was the bubble.
      StRun, StLu: begin
        if (redirect) begin
          IF_flush = 1'b1;
          state_d  = StFlush;
        end else if (lu_run) begin
          ID_stall = 1'b1;
          state_d  = StLu;
        end else if (!s0_valid) begin
          // Nothing issuable in lane 0: insert a bubble and move on.
          IF_flush = 1'b1;
          pc_step  = 4'd4;
          state_d  = StRun;
        end else if (s0_multi) begin
          pc_step = 4'd4;
          state_d = StMcw;
        end else if (pair_ok) begin
          two_issue = 1'b1;
          pc_step   = 4'd8;
          state_d   = StRun;
        end else if (s1_valid) begin
          // Issue slot0 now; fetch holds the pair so slot1 issues next cycle.
          state_d = StSplit;
        end else begin
          pc_step = 4'd4;
          state_d = StRun;
        end
      end
      StSplit: begin
        if (redirect) begin
          IF_flush = 1'b1;
          state_d  = StFlush;
        end else begin
          issue_sel = 1'b1;
          if (s1_lu) begin
            ID_stall = 1'b1;
            state_d  = StSplit;
          end else if (s1_multi) begin
            pc_step = 4'd8;
            state_d = StMcw;
          end else begin
            pc_step = 4'd8;
            state_d = StRun;
          end
        end
      end
      StMcw: begin
        if (redirect) begin
          IF_flush = 1'b1;
          state_d  = StFlush;
        end else begin
          ID_stall = 1'b1;
          if (mc_done) begin
            state_d = StRun;
          end
        end
      end
      StFlush: begin
        IF_flush = 1'b1;
        state_d  = StRun;
      end
      default: begin
        state_d = StRun;
      end
    endcase

    if (!rst) begin
      ID_stall  = 1'b0;
      IF_flush  = 1'b0;
      two_issue = 1'b0;
      issue_sel = 1'b0;
      pc_step   = 4'd0;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_issue_ctrl.sv
// Self-checking bench for issue_ctrl: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_issue_ctrl;

  logic       clk;
  logic       rst;
  logic       s0_valid, s1_valid;
  logic [4:0] s0_rs1, s0_rs2, s0_rd, s1_rs1, s1_rs2, s1_rd;
  logic       s0_reg_write, s1_reg_write, s0_mem, s1_mem;
  logic       s0_branch, s1_branch, s0_multi, s1_multi;
  logic       ex_load0, ex_load1;
  logic [4:0] ex_rd0, ex_rd1;
  logic       mc_done, redirect;
  logic       ID_stall, IF_flush, two_issue, issue_sel;
  logic [3:0] pc_step;
  logic [2:0] state;

  int checks;
  int failures;
  bit cmp_en;
  int m_mode;

  localparam int MRun = 0, MSplit = 1, MLu = 2, MMcw = 3, MFlush = 4;

  typedef struct packed {
    logic       stall;
    logic       flush;
    logic       two;
    logic       sel;
    logic [3:0] pc;
    logic [2:0] nxt;
  } exp_t;

  issue_ctrl dut (
    .clk(clk), .rst(rst),
    .s0_valid(s0_valid), .s1_valid(s1_valid),
    .s0_rs1(s0_rs1), .s0_rs2(s0_rs2), .s0_rd(s0_rd),
    .s1_rs1(s1_rs1), .s1_rs2(s1_rs2), .s1_rd(s1_rd),
    .s0_reg_write(s0_reg_write), .s1_reg_write(s1_reg_write),
    .s0_mem(s0_mem), .s1_mem(s1_mem),
    .s0_branch(s0_branch), .s1_branch(s1_branch),
    .s0_multi(s0_multi), .s1_multi(s1_multi),
    .ex_load0(ex_load0), .ex_load1(ex_load1),
    .ex_rd0(ex_rd0), .ex_rd1(ex_rd1),
    .mc_done(mc_done), .redirect(redirect),
    .ID_stall(ID_stall), .IF_flush(IF_flush), .two_issue(two_issue),
    .issue_sel(issue_sel), .pc_step(pc_step), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Does register r depend on a load still in EX?
  function automatic bit uses_load(input logic [4:0] r);
    return (r != 0) && ((ex_load0 && r == ex_rd0) || (ex_load1 && r == ex_rd1));
  endfunction

  function automatic bit slot_blocked(input int s);
    if (s == 0) return uses_load(s0_rs1) || uses_load(s0_rs2);
    return uses_load(s1_rs1) || uses_load(s1_rs2);
  endfunction

  // Expected outputs and next mode, derived from the scheduling rules.
  function automatic exp_t model_eval(input int mode);
    exp_t e;
    bit   conflict;
    bit   dual;
    int   n;
    e = '0;
    e.nxt = mode[2:0];
    conflict = (s0_reg_write && s0_rd != 0 && (s1_rs1 == s0_rd || s1_rs2 == s0_rd)) ||
               (s0_mem && s1_mem) || s0_branch || s0_multi || s1_multi;
    dual = s0_valid && s1_valid && !conflict;
    n = dual ? 2 : (s0_valid ? 1 : 0);
    case (mode)
      MRun, MLu: begin
        if (redirect) begin
          e.flush = 1; e.nxt = MFlush;
        end else if ((n >= 1 && slot_blocked(0)) || (n == 2 && slot_blocked(1))) begin
          e.stall = 1; e.nxt = MLu;
        end else if (n == 0) begin
          e.flush = 1; e.pc = 4; e.nxt = MRun;
        end else if (s0_multi) begin
          e.pc = 4; e.nxt = MMcw;
        end else if (dual) begin
          e.two = 1; e.pc = 8; e.nxt = MRun;
        end else if (s1_valid) begin
          e.pc = 0; e.nxt = MSplit;
        end else begin
          e.pc = 4; e.nxt = MRun;
        end
      end
      MSplit: begin
        if (redirect) begin
          e.flush = 1; e.nxt = MFlush;
        end else begin
          e.sel = 1;
          if (slot_blocked(1)) begin e.stall = 1; e.nxt = MSplit; end
          else begin e.pc = 8; e.nxt = s1_multi ? 3'(MMcw) : 3'(MRun); end
        end
      end
      MMcw: begin
        if (redirect) begin
          e.flush = 1; e.nxt = MFlush;
        end else begin
          e.stall = 1; e.nxt = mc_done ? 3'(MRun) : 3'(MMcw);
        end
      end
      MFlush: begin
        e.flush = 1; e.nxt = MRun;
      end
      default: e.nxt = MRun;
    endcase
    return e;
  endfunction

  // Model mode advances on the same edge as the DUT.
  always @(posedge clk) begin
    exp_t e;
    e = model_eval(m_mode);
    if (!rst) m_mode <= MRun;
    else m_mode <= int'(e.nxt);
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (cmp_en) begin
      e = model_eval(m_mode);
      if (!rst) begin
        e.stall = 0; e.flush = 0; e.two = 0; e.sel = 0; e.pc = 0;
      end
      chk("m_state", 32'(state), 32'(m_mode));
      chk("m_ID_stall", 32'(ID_stall), 32'(e.stall));
      chk("m_IF_flush", 32'(IF_flush), 32'(e.flush));
      chk("m_two_issue", 32'(two_issue), 32'(e.two));
      chk("m_issue_sel", 32'(issue_sel), 32'(e.sel));
      chk("m_pc_step", 32'(pc_step), 32'(e.pc));
      chk("inv_stall_flush", 32'(ID_stall & IF_flush), 32'd0);
    end
  end

  task automatic clr();
    s0_valid = 0; s1_valid = 0;
    s0_rs1 = 0; s0_rs2 = 0; s0_rd = 0; s1_rs1 = 0; s1_rs2 = 0; s1_rd = 0;
    s0_reg_write = 0; s1_reg_write = 0; s0_mem = 0; s1_mem = 0;
    s0_branch = 0; s1_branch = 0; s0_multi = 0; s1_multi = 0;
    ex_load0 = 0; ex_load1 = 0; ex_rd0 = 0; ex_rd1 = 0;
    mc_done = 0; redirect = 0;
  endtask

  task automatic rnd();
    s0_valid = ($urandom_range(0, 3) != 0);
    s1_valid = ($urandom_range(0, 3) != 0);
    s0_rs1 = 5'($urandom_range(0, 7)); s0_rs2 = 5'($urandom_range(0, 7));
    s0_rd  = 5'($urandom_range(0, 7)); s1_rs1 = 5'($urandom_range(0, 7));
    s1_rs2 = 5'($urandom_range(0, 7)); s1_rd  = 5'($urandom_range(0, 7));
    s0_reg_write = $urandom_range(0, 1) != 0; s1_reg_write = $urandom_range(0, 1) != 0;
    s0_mem = ($urandom_range(0, 3) == 0); s1_mem = ($urandom_range(0, 3) == 0);
    s0_branch = ($urandom_range(0, 7) == 0); s1_branch = ($urandom_range(0, 7) == 0);
    s0_multi = ($urandom_range(0, 7) == 0); s1_multi = ($urandom_range(0, 7) == 0);
    ex_load0 = ($urandom_range(0, 3) == 0); ex_load1 = ($urandom_range(0, 3) == 0);
    ex_rd0 = 5'($urandom_range(0, 7)); ex_rd1 = 5'($urandom_range(0, 7));
    mc_done = ($urandom_range(0, 5) == 0);
    redirect = ($urandom_range(0, 15) == 0);
  endtask

  // s0: add x5,x1,x2  s1: add x6,x1,x2
  task automatic indep_pair();
    clr();
    s0_valid = 1; s1_valid = 1;
    s0_rd = 5; s0_rs1 = 1; s0_rs2 = 2; s0_reg_write = 1;
    s1_rd = 6; s1_rs1 = 1; s1_rs2 = 2; s1_reg_write = 1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0; failures = 0; cmp_en = 0; m_mode = MRun;
    clr();
    rst = 0;
    rnd();
    step();
    cmp_en = 1;
    rnd();
    step();
    #2;
    chk("rst_state", 32'(state), 0);
    chk("rst_ID_stall", 32'(ID_stall), 0);
    chk("rst_IF_flush", 32'(IF_flush), 0);
    chk("rst_two_issue", 32'(two_issue), 0);
    chk("rst_pc_step", 32'(pc_step), 0);
    rst = 1;
    clr();
    step();

    // Independent pair dual-issues.
    indep_pair();
    #2;
    chk("indep_two_issue", 32'(two_issue), 1);
    chk("indep_pc_step", 32'(pc_step), 8);
    step();
    chk("indep_state", 32'(state), 0);

    // RAW inside the pair splits.
    s1_rs1 = 5;
    #2;
    chk("raw_two_issue", 32'(two_issue), 0);
    chk("raw_pc_step", 32'(pc_step), 0);
    step();
    #2;
    chk("raw_state_split", 32'(state), 1);
    chk("raw_issue_sel", 32'(issue_sel), 1);
    chk("raw_split_pc", 32'(pc_step), 8);
    step();
    chk("raw_state_run", 32'(state), 0);

    // Load-use on slot0 rs2.
    indep_pair();
    s0_rs2 = 7; ex_load0 = 1; ex_rd0 = 7;
    #2;
    chk("lu_stall", 32'(ID_stall), 1);
    chk("lu_pc_step", 32'(pc_step), 0);
    step();
    ex_load0 = 0;
    #2;
    chk("lu_state", 32'(state), 2);
    chk("lu_reissue_two", 32'(two_issue), 1);
    chk("lu_reissue_pc", 32'(pc_step), 8);
    step();
    chk("lu_back_run", 32'(state), 0);

    // Multi-cycle op waits for mc_done.
    clr();
    s0_valid = 1; s0_multi = 1; s0_rs1 = 3; s0_rd = 4; s0_reg_write = 1;
    #2;
    chk("mc_pc_step", 32'(pc_step), 4);
    chk("mc_two_issue", 32'(two_issue), 0);
    step();
    clr();
    for (int i = 0; i < 5; i++) begin
      #2;
      chk("mc_wait_stall", 32'(ID_stall), 1);
      chk("mc_wait_state", 32'(state), 3);
      step();
    end
    mc_done = 1;
    #2;
    chk("mc_done_stall", 32'(ID_stall), 1);
    step();
    mc_done = 0;
    chk("mc_back_run", 32'(state), 0);

    // Redirect during SPLIT.
    indep_pair();
    s1_rs2 = 5;
    step();
    redirect = 1;
    #2;
    chk("rs_split_flush", 32'(IF_flush), 1);
    chk("rs_split_pc", 32'(pc_step), 0);
    step();
    redirect = 0;
    #2;
    chk("rs_flush_state", 32'(state), 4);
    chk("rs_flush2", 32'(IF_flush), 1);
    chk("rs_flush_pc", 32'(pc_step), 0);
    step();
    chk("rs_back_run", 32'(state), 0);

    // Redirect with simultaneous mc_done in MCW.
    clr();
    s0_valid = 1; s0_multi = 1;
    step();
    clr();
    redirect = 1; mc_done = 1;
    #2;
    chk("rm_flush", 32'(IF_flush), 1);
    chk("rm_no_stall", 32'(ID_stall), 0);
    step();
    clr();
    #2;
    chk("rm_flush_state", 32'(state), 4);
    chk("rm_flush2", 32'(IF_flush), 1);
    step();
    chk("rm_back_run", 32'(state), 0);

    // Reset mid-wait.
    s0_valid = 1; s0_multi = 1;
    step();
    clr();
    rst = 0;
    #2;
    chk("mrst_stall", 32'(ID_stall), 0);
    step();
    rst = 1;
    chk("mrst_state", 32'(state), 0);

    // Randomized traffic; checked by the per-cycle compare process.
    for (int i = 0; i < 4000; i++) begin
      rnd();
      rst = ($urandom_range(0, 63) != 0);
      step();
    end
    rst = 1;
    clr();
    step();
    @(negedge clk);
    #1;
    cmp_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
